// File: rtl/nv_ram_rwsp_fifo_ctrl_160x16_pkg.sv
// Shared sizing constants and pointer helpers for the 160x16 RAM-backed FIFO controller.
package nv_ram_rwsp_fifo_ctrl_160x16_pkg;
   localparam int DEPTH  = 160;
   localparam int WIDTH  = 16;
   localparam int AW     = 8;
   localparam int CW     = 8;
   localparam int OBUF_D = 3;

   localparam logic [AW-1:0] PTR_LAST = 8'd159;
   localparam logic [CW-1:0] CNT_FULL = 8'd160;

   typedef logic [WIDTH-1:0] data_t;
   typedef logic [AW-1:0]    addr_t;
   typedef logic [CW-1:0]    cnt_t;

   function automatic addr_t ptr_inc(input addr_t p);
      return (p == PTR_LAST) ? 8'd0 : p + 8'd1;
   endfunction

   function automatic logic [1:0] obuf_idx_inc(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction
endpackage

// File: rtl/nv_ram_rwsp_fifo_ctrl_160x16_if.sv
// Client-side valid/ready FIFO interface: write channel, read channel and occupancy.
interface nv_ram_rwsp_fifo_ctrl_160x16_if;
   import nv_ram_rwsp_fifo_ctrl_160x16_pkg::*;

   logic  wr_pvld;
   logic  wr_prdy;
   data_t wr_pd;
   logic  rd_pvld;
   logic  rd_prdy;
   data_t rd_pd;
   cnt_t  fifo_count;

   modport master (output wr_pvld, output wr_pd, output rd_prdy,
                   input wr_prdy, input rd_pvld, input rd_pd, input fifo_count);
   modport slave  (input wr_pvld, input wr_pd, input rd_prdy,
                   output wr_prdy, output rd_pvld, output rd_pd, output fifo_count);
endinterface

// File: rtl/nv_ram_rwsp_fifo_ctrl_160x16_obuf.sv
// Three-entry registered output buffer that absorbs RAM read data and presents it as valid/ready.
module nv_ram_rwsp_fifo_ctrl_160x16_obuf
   import nv_ram_rwsp_fifo_ctrl_160x16_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  data_t      din,
   output logic       pvld,
   input  logic       prdy,
   output data_t      pd,
   output logic [1:0] count
);
   data_t      mem [OBUF_D];
   logic [1:0] head;
   logic [1:0] tail;
   logic [1:0] cnt;
   logic       pop;

   assign pop   = pvld & prdy;
   assign pvld  = (cnt != 2'd0);
   assign pd    = mem[head];
   assign count = cnt;

   // Ring storage; push into a full buffer is legal only alongside a pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= 2'd0;
         tail <= 2'd0;
         cnt  <= 2'd0;
         for (int i = 0; i < OBUF_D; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[tail] <= din;
            tail      <= obuf_idx_inc(tail);
         end
         if (pop) begin
            head <= obuf_idx_inc(head);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl_160x16.sv
// FIFO controller driving a 160x16 two-port RAM with a two-cycle read, hidden behind an output buffer.
module nv_ram_rwsp_fifo_ctrl_160x16
   import nv_ram_rwsp_fifo_ctrl_160x16_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset,
   nv_ram_rwsp_fifo_ctrl_160x16_if.slave   fifo,
   output addr_t                           ram_wa,
   output logic                            ram_we,
   output data_t                           ram_di,
   output addr_t                           ram_ra,
   output logic                            ram_re,
   output logic                            ram_ore,
   input  data_t                           ram_dout
);
   addr_t      wptr;
   addr_t      rptr;
   cnt_t       ram_cnt;
   logic       s1;
   logic       s2;
   logic       wr_prdy;
   logic       wr_acc;
   logic       obuf_pvld;
   logic       pop;
   logic       issue;
   logic [1:0] obuf_cnt;
   logic [2:0] used;

   // Readiness uses only the registered RAM count, so a same-cycle issue never frees a write slot.
   assign wr_prdy = !reset && (ram_cnt != CNT_FULL);
   assign wr_acc  = fifo.wr_pvld & wr_prdy;
   assign pop     = fifo.rd_pvld & fifo.rd_prdy;

   // Credit: buffered plus in-flight reads, less this cycle's pop, must leave room in the buffer.
   assign used  = {1'b0, obuf_cnt} + {2'b00, s1} + {2'b00, s2};
   assign issue = !reset && (ram_cnt != 8'd0) && (used < (3'd3 + {2'b00, pop}));

   assign fifo.wr_prdy    = wr_prdy;
   assign fifo.rd_pvld    = obuf_pvld & !reset;
   assign fifo.fifo_count = reset ? 8'd0
                                  : ram_cnt + {7'd0, s1} + {7'd0, s2} + {6'd0, obuf_cnt};

   assign ram_we  = wr_acc;
   assign ram_wa  = wptr;
   assign ram_di  = fifo.wr_pd;
   assign ram_re  = issue;
   assign ram_ra  = rptr;
   assign ram_ore = s1 & !reset;

   // Pointers, RAM occupancy and the two-stage read-latency tracker.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr    <= 8'd0;
         rptr    <= 8'd0;
         ram_cnt <= 8'd0;
         s1      <= 1'b0;
         s2      <= 1'b0;
      end else begin
         if (wr_acc) begin
            wptr <= ptr_inc(wptr);
         end
         if (issue) begin
            rptr <= ptr_inc(rptr);
         end
         s1 <= issue;
         s2 <= s1;
         case ({wr_acc, issue})
            2'b10:   ram_cnt <= ram_cnt + 8'd1;
            2'b01:   ram_cnt <= ram_cnt - 8'd1;
            default: ram_cnt <= ram_cnt;
         endcase
      end
   end

   nv_ram_rwsp_fifo_ctrl_160x16_obuf u_obuf (
      .clk   (clk),
      .reset (reset),
      .push  (s2 & !reset),
      .din   (ram_dout),
      .pvld  (obuf_pvld),
      .prdy  (fifo.rd_prdy),
      .pd    (fifo.rd_pd),
      .count (obuf_cnt)
   );
endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl_160x16.sv
// Directed plus randomized bench for the 160x16 RAM FIFO controller with a queue-based reference model.
module tb_nv_ram_rwsp_fifo_ctrl_160x16;
   import nv_ram_rwsp_fifo_ctrl_160x16_pkg::*;

   logic  clk = 1'b0;
   logic  reset;
   addr_t ram_wa, ram_ra, ra_q;
   logic  ram_we, ram_re, ram_ore;
   data_t ram_di, ram_dout, dout_q;
   data_t ram_mem [DEPTH];

   always #5 clk = ~clk;

   nv_ram_rwsp_fifo_ctrl_160x16_if bus ();

   nv_ram_rwsp_fifo_ctrl_160x16 dut (
      .clk      (clk),
      .reset    (reset),
      .fifo     (bus),
      .ram_wa   (ram_wa),
      .ram_we   (ram_we),
      .ram_di   (ram_di),
      .ram_ra   (ram_ra),
      .ram_re   (ram_re),
      .ram_ore  (ram_ore),
      .ram_dout (ram_dout)
   );

   // RAM model: address captured at re, output register loaded at ore.
   always @(posedge clk) begin
      if (ram_we && ram_wa < 8'd160) ram_mem[ram_wa] <= ram_di;
      if (ram_re) ra_q <= ram_ra;
      if (ram_ore) dout_q <= ram_mem[ra_q];
   end
   assign ram_dout = dout_q;

   int    ntests = 0;
   int    nfail  = 0;
   data_t q[$];
   int    wa_exp = 0, ra_exp = 0, wa_wraps = 0, ra_wraps = 0;
   int    cyc = 0, nrd = 0, first_pop_cyc = -1, last_pop_cyc = -1;
   data_t last_pop_pd;
   logic  prev_stall = 1'b0;
   data_t prev_pd;

   logic  s_rst, s_wv, s_wprdy, s_we, s_re, s_ore, s_pvld, s_prdy;
   data_t s_pd, s_di, s_wd;
   addr_t s_wa, s_ra;
   cnt_t  s_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample mid-cycle, check against the model, then advance the model past the edge.
   task automatic step();
      @(negedge clk);
      s_rst = reset;  s_wv = bus.wr_pvld; s_wprdy = bus.wr_prdy; s_wd = bus.wr_pd;
      s_we = ram_we;  s_wa = ram_wa; s_di = ram_di; s_re = ram_re; s_ra = ram_ra;
      s_ore = ram_ore; s_pvld = bus.rd_pvld; s_prdy = bus.rd_prdy; s_pd = bus.rd_pd;
      s_cnt = bus.fifo_count;
      chk("count", s_cnt, s_rst ? 0 : q.size());
      chk("we_is_acc", s_we, s_wv & s_wprdy);
      if (s_we) begin
         chk("wa", s_wa, wa_exp);
         chk("di", s_di, s_wd);
      end
      if (s_re) chk("ra", s_ra, ra_exp);
      if (!s_rst && prev_stall) begin
         chk("stall_vld", s_pvld, 1'b1);
         chk("stall_pd", s_pd, prev_pd);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_rst) begin
         q.delete();
         wa_exp = 0; ra_exp = 0; prev_stall = 1'b0;
      end else begin
         if (s_pvld && s_prdy) begin
            if (q.size() == 0) chk("pop_empty", s_pvld, 1'b0);
            else chk("order", s_pd, q.pop_front());
            nrd++;
            last_pop_pd = s_pd;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         if (s_wv && s_wprdy) begin
            q.push_back(s_wd);
            if (wa_exp == DEPTH - 1) begin wa_exp = 0; wa_wraps++; end
            else wa_exp++;
         end
         if (s_re) begin
            if (ra_exp == DEPTH - 1) begin ra_exp = 0; ra_wraps++; end
            else ra_exp++;
         end
         prev_stall = s_pvld && !s_prdy;
         prev_pd    = s_pd;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0; bus.wr_pd = 16'h0;
      step();
      chk("rst_wprdy", s_wprdy, 1'b0);
      chk("rst_pvld", s_pvld, 1'b0);
      chk("rst_re", s_re, 1'b0);
      chk("rst_ore", s_ore, 1'b0);
      chk("rst_cnt", s_cnt, 8'd0);
      reset = 1'b0;
      wa_wraps = 0; ra_wraps = 0; nrd = 0; first_pop_cyc = -1; last_pop_cyc = -1;
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int w, acc;
      reset = 1'b1; bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0; bus.wr_pd = 16'h0;
      repeat (2) step();
      do_reset();

      // 1: single write latency
      bus.rd_prdy = 1'b1; bus.wr_pvld = 1'b1; bus.wr_pd = 16'h1234;
      step();
      chk("t1_we_N", s_we, 1'b1);
      chk("t1_wa_N", s_wa, 8'd0);
      bus.wr_pvld = 1'b0;
      step();
      chk("t1_re_N1", s_re, 1'b1);
      chk("t1_ra_N1", s_ra, 8'd0);
      chk("t1_ore_N1", s_ore, 1'b0);
      step();
      chk("t1_ore_N2", s_ore, 1'b1);
      chk("t1_re_N2", s_re, 1'b0);
      step();
      chk("t1_pvld_N3", s_pvld, 1'b0);
      step();
      chk("t1_pvld_N4", s_pvld, 1'b1);
      chk("t1_pd_N4", s_pd, 16'h1234);
      step();
      chk("t1_cnt_end", s_cnt, 8'd0);

      // 2: fill to capacity with reads stalled
      do_reset();
      bus.wr_pvld = 1'b1;
      for (int i = 0; i < 160; i++) begin
         bus.wr_pd = 16'($urandom);
         step();
         chk("t2_fill_rdy", s_wprdy, 1'b1);
      end
      bus.wr_pvld = 1'b0;
      repeat (6) step();
      chk("t2_cnt160", s_cnt, 8'd160);
      chk("t2_pvld", s_pvld, 1'b1);
      bus.wr_pvld = 1'b1;
      acc = 0;
      for (int i = 0; i < 10 && acc < 3; i++) begin
         bus.wr_pd = 16'($urandom);
         step();
         if (s_wv && s_wprdy) acc++;
      end
      chk("t2_extra_acc", acc, 3);
      step();
      chk("t2_full_rdy", s_wprdy, 1'b0);
      chk("t2_full_we", s_we, 1'b0);
      chk("t2_cnt163", s_cnt, 8'd163);

      // 6: pop one from full
      bus.rd_prdy = 1'b1;
      step();
      chk("t6_pop_vld", s_pvld, 1'b1);
      chk("t6_pop_cycle_rdy", s_wprdy, 1'b0);
      chk("t6_pop_issue", s_re, 1'b1);
      bus.rd_prdy = 1'b0;
      step();
      chk("t6_rdy_back", s_wprdy, 1'b1);
      step();
      chk("t6_full_again", s_wprdy, 1'b0);
      bus.wr_pvld = 1'b0;

      // 3: sustained streaming with pointer wrap
      do_reset();
      bus.rd_prdy = 1'b1;
      w = 0;
      for (int c = 0; c < 700 && nrd < 500; c++) begin
         bus.wr_pvld = (w < 500);
         bus.wr_pd = 16'(w);
         step();
         if (s_wv && s_wprdy) w++;
      end
      chk("t3_reads", nrd, 500);
      chk("t3_span", last_pop_cyc - first_pop_cyc, 499);
      chk("t3_wa_wraps", wa_wraps, 3);
      chk("t3_ra_wraps", ra_wraps, 3);

      // 4: random writes and stalls
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bus.wr_pvld = 1'($urandom);
         bus.wr_pd = 16'($urandom);
         bus.rd_prdy = 1'($urandom);
         step();
      end
      bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b1;
      for (int c = 0; c < 300 && q.size() != 0; c++) step();
      step();
      chk("t4_drain", bus.fifo_count, 8'd0);

      // 5: reset mid-stream
      do_reset();
      bus.wr_pvld = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.wr_pd = 16'($urandom);
         step();
      end
      chk("t5_held", s_cnt, 8'd39);
      reset = 1'b1; bus.wr_pvld = 1'b0;
      step();
      chk("t5_rst_pvld", s_pvld, 1'b0);
      chk("t5_rst_re", s_re, 1'b0);
      reset = 1'b0;
      step();
      chk("t5_post_pvld", s_pvld, 1'b0);
      chk("t5_post_cnt", s_cnt, 8'd0);
      chk("t5_post_re", s_re, 1'b0);
      nrd = 0;
      bus.wr_pvld = 1'b1; bus.wr_pd = 16'hBEEF; bus.rd_prdy = 1'b1;
      step();
      bus.wr_pvld = 1'b0;
      for (int c = 0; c < 20 && nrd == 0; c++) step();
      chk("t5_first_read_cnt", nrd, 1);
      chk("t5_first_word", last_pop_pd, 16'hBEEF);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
